// File: rtl/sd_lane_shift_reg_if.sv
// Bus bundle for the SD DAT lane serialiser: pad-side lanes, control strobes and
// both word handshakes. master drives the block, slave is the block itself.
interface sd_lane_shift_reg_if #(
  parameter int unsigned NumBits  = 32,
  parameter int unsigned MaxLanes = 8
);
  logic                clk_en_i;
  logic                start_i;
  logic                stop_i;
  logic                dir_i;
  logic [1:0]          lanes_i;
  logic [MaxLanes-1:0] dat_i;
  logic [MaxLanes-1:0] dat_o;
  logic                dat_oe_o;
  logic [NumBits-1:0]  rx_data_o;
  logic                rx_valid_o;
  logic                rx_ready_i;
  logic [NumBits-1:0]  tx_data_i;
  logic                tx_valid_i;
  logic                tx_ready_o;
  logic                word_done_o;
  logic                overrun_o;
  logic                underrun_o;
  logic                busy_o;

  modport master (
    output clk_en_i, start_i, stop_i, dir_i, lanes_i, dat_i, rx_ready_i, tx_data_i, tx_valid_i,
    input  dat_o, dat_oe_o, rx_data_o, rx_valid_o, tx_ready_o, word_done_o, overrun_o,
           underrun_o, busy_o
  );

  modport slave (
    input  clk_en_i, start_i, stop_i, dir_i, lanes_i, dat_i, rx_ready_i, tx_data_i, tx_valid_i,
    output dat_o, dat_oe_o, rx_data_o, rx_valid_o, tx_ready_o, word_done_o, overrun_o,
           underrun_o, busy_o
  );
endinterface

// File: rtl/sd_lane_shift_reg.sv
// Bidirectional 1/4/8-lane SD DAT serialiser/deserialiser (MSb first) with one word of
// buffering per direction and valid/ready handshakes on the word side.
module sd_lane_shift_reg #(
  parameter int unsigned NumBits  = 32,
  parameter int unsigned MaxLanes = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  sd_lane_shift_reg_if.slave  bus
);
  localparam int unsigned CntW = (NumBits > 1) ? $clog2(NumBits) : 1;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t Last1 = cnt_t'(NumBits - 1);
  localparam cnt_t Last4 = cnt_t'(NumBits / 4 - 1);
  localparam cnt_t Last8 = cnt_t'(NumBits / 8 - 1);

  typedef enum logic [1:0] {StIdle, StRx, StTx} state_e;

  state_e             r_state, w_state_d;
  logic [1:0]         r_lsel, w_start_lsel;
  logic [NumBits-1:0] r_sr, r_hold, r_rx_buf;
  cnt_t               r_cnt, w_last;
  logic               r_full, r_hold_valid, r_rx_valid, r_overrun, r_underrun;

  int unsigned        w_lanes;
  logic [7:0]         w_mask8, w_dat_ext, w_top8, w_dat8;
  logic [NumBits-1:0] w_rx_shift, w_tx_src;
  logic               w_start, w_stop, w_at_last, w_rx_beat, w_rx_done;
  logic               w_tx_shift, w_tx_load, w_underrun_ev, w_hold_take;

  always_comb begin
    w_start_lsel = 2'd0;
    if (bus.lanes_i == 2'b01 && MaxLanes >= 4)      w_start_lsel = 2'd1;
    else if (bus.lanes_i == 2'b10 && MaxLanes >= 8) w_start_lsel = 2'd2;
  end

  always_comb begin
    w_lanes = 1;
    w_mask8 = 8'h01;
    w_last  = Last1;
    case (r_lsel)
      2'd1: begin w_lanes = 4; w_mask8 = 8'h0F; w_last = Last4; end
      2'd2: begin w_lanes = 8; w_mask8 = 8'hFF; w_last = Last8; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (bus.start_i && !bus.stop_i) w_state_d = bus.dir_i ? StTx : StRx;
      StRx, StTx: if (bus.stop_i) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  assign w_start       = (r_state == StIdle) && bus.start_i && !bus.stop_i;
  assign w_stop        = (r_state != StIdle) && bus.stop_i;
  assign w_at_last     = (r_cnt == w_last);
  assign w_dat_ext     = 8'(bus.dat_i) & w_mask8;
  assign w_rx_shift    = (r_sr << w_lanes) | NumBits'(w_dat_ext);
  assign w_rx_beat     = (r_state == StRx) && !bus.stop_i && bus.clk_en_i;
  assign w_rx_done     = w_rx_beat && w_at_last;
  assign w_tx_shift    = (r_state == StTx) && !bus.stop_i && bus.clk_en_i && r_full;
  assign w_tx_load     = (r_state == StTx) && !bus.stop_i && bus.clk_en_i && !r_full && r_hold_valid;
  assign w_underrun_ev = (r_state == StTx) && !bus.stop_i && bus.clk_en_i && !r_full &&
                         !r_hold_valid;
  assign w_hold_take   = bus.tx_valid_i && (!r_hold_valid || w_tx_load);

  // An empty shift register shows the waiting word so its first beat is on the lanes
  // during the load cycle itself.
  assign w_tx_src = r_full ? r_sr : r_hold;
  assign w_top8   = 8'(w_tx_src >> (NumBits - w_lanes)) & w_mask8;
  assign w_dat8   = ((r_state == StTx) && (r_full || r_hold_valid)) ? (w_top8 | ~w_mask8) : 8'hFF;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_lsel       <= 2'd0;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_full       <= 1'b0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_rx_buf     <= '0;
      r_rx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_state <= w_state_d;

      if (w_start) begin
        r_lsel     <= w_start_lsel;
        r_sr       <= '0;
        r_cnt      <= '0;
        r_full     <= 1'b0;
        r_overrun  <= 1'b0;
        r_underrun <= 1'b0;
      end else if (w_stop) begin
        r_sr   <= '0;
        r_cnt  <= '0;
        r_full <= 1'b0;
      end else if (w_rx_beat) begin
        r_sr  <= w_rx_shift;
        r_cnt <= w_at_last ? '0 : r_cnt + cnt_t'(1);
      end else if (w_tx_shift) begin
        r_sr  <= r_sr << w_lanes;
        r_cnt <= w_at_last ? '0 : r_cnt + cnt_t'(1);
        if (w_at_last) r_full <= 1'b0;
      end else if (w_tx_load) begin
        // The load cycle already carries beat 0, so keep only the remaining beats.
        r_sr   <= r_hold << w_lanes;
        r_cnt  <= cnt_t'(1);
        r_full <= 1'b1;
      end else if (w_underrun_ev) begin
        r_underrun <= 1'b1;
      end

      if (w_rx_done && (!r_rx_valid || bus.rx_ready_i)) begin
        r_rx_buf   <= w_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_done && r_rx_valid && !bus.rx_ready_i) r_overrun <= 1'b1;

      if (w_hold_take) begin
        r_hold       <= bus.tx_data_i;
        r_hold_valid <= 1'b1;
      end else if (w_tx_load) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign bus.dat_o       = w_dat8[MaxLanes-1:0];
  assign bus.dat_oe_o    = (r_state == StTx);
  assign bus.rx_data_o   = r_rx_valid ? r_rx_buf : '0;
  assign bus.rx_valid_o  = r_rx_valid;
  assign bus.tx_ready_o  = !rst_i && !r_hold_valid;
  assign bus.word_done_o = (w_rx_beat || w_tx_shift) && w_at_last;
  assign bus.overrun_o   = r_overrun;
  assign bus.underrun_o  = r_underrun;
  assign bus.busy_o      = (r_state != StIdle);
endmodule

// File: doc/sd_lane_shift_reg.md
Name: sd_lane_shift_reg

Overview:
- Bidirectional, multi-lane serialiser/deserialiser for the SDHCI data path.
- It converts between the SD DAT lines (1, 4 or 8 lanes, MSb first) and NumBits-wide words.
- Words move on a valid/ready handshake, with one word of buffering per direction.
- It sits between the SD bus I/O pads (advanced by the SD-clock enable) and the data FIFO/DMA side.

Parameters:
- NumBits, 32: word width. Must be a multiple of MaxLanes.
- MaxLanes, 8: physical DAT lanes. Must be 1, 4 or 8.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: asynchronous, active-high reset.
- clk_en_i, input, 1: SD bit-clock enable. State advances only on cycles where it is high, except handshakes and start/stop.
- start_i, input, 1: begin a transfer. Only honoured in IDLE.
- stop_i, input, 1: abort or finish the transfer; go to IDLE.
- dir_i, input, 1: 0 = RX (lanes to word), 1 = TX (word to lanes). Sampled at start.
- lanes_i, input, 2: 00 = 1 lane, 01 = 4 lanes, 10 = 8 lanes, 11 = 1 lane. Sampled at start. Any encoding above MaxLanes maps to 1 lane.
- dat_i, input, MaxLanes: serial input lanes.
- dat_o, output, MaxLanes: serial output lanes.
- dat_oe_o, output, 1: output enable for the DAT lanes.
- rx_data_o, output, NumBits: received word.
- rx_valid_o, output, 1: received word available.
- rx_ready_i, input, 1: downstream accepts the received word.
- tx_data_i, input, NumBits: word to transmit.
- tx_valid_i, input, 1: transmit word offered.
- tx_ready_o, output, 1: transmit holding buffer is empty.
- word_done_o, output, 1: one-cycle pulse when a word finishes shifting.
- overrun_o, output, 1: sticky RX overrun flag.
- underrun_o, output, 1: sticky TX underrun flag.
- busy_o, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_i=1):
  - FSM goes to IDLE; shift register, beat counter, buffers and flags clear.
  - Output values during reset: dat_o all 1s, dat_oe_o=0, rx_valid_o=0, rx_data_o=0, tx_ready_o=0, word_done_o=0, overrun_o=0, underrun_o=0, busy_o=0.
- Beats per word: B = NumBits/L, where L is the active lane count latched at start. The beat counter runs 0..B-1 and wraps.
- FSM states: IDLE, RX, TX.
  - IDLE to RX or TX: start_i=1. On that cycle, latch L and dir, zero the counter, clear overrun_o/underrun_o. Takes effect next cycle.
  - RX or TX to IDLE: stop_i=1.
    - stop_i has priority over start_i, shifting and loading.
    - The partial word in the shift register is discarded; the counter is cleared.
    - A pending rx word and the tx holding buffer are retained.
  - start_i outside IDLE is ignored.
- RX, each cycle with clk_en_i=1:
  - Shift register shifts left by L; dat_i[L-1:0] enters the LSbs, with dat_i[L-1] the most significant of the beat.
  - On beat B-1, the completed word (including this beat) moves to the rx buffer and word_done_o pulses.
  - rx_valid_o rises the next cycle.
  - If the rx buffer is still valid at that moment, the new word is dropped, the old word is kept, and overrun_o sets (sticky until next start).
  - Completion and rx_ready_i on the same cycle: the old word is consumed and the new word is stored. No overrun.
- rx handshake: a word transfers when rx_valid_o && rx_ready_i. rx_data_o holds stable while valid. rx_data_o is 0 when not valid.
- TX output:
  - tx_ready_o = holding buffer empty, in any state except reset.
  - In TX, dat_oe_o=1 and dat_o[L-1:0] = top L bits of the shift register; unused lanes drive 1.
- TX shifting and loading:
  - The shift register is empty at start and after beat B-1.
  - Cycle with clk_en_i=1, shift register loaded: shift left by L; at beat B-1, pulse word_done_o and mark the shift register empty.
  - Cycle with clk_en_i=1, shift register empty and holding buffer valid: load the shift register (no shift this cycle) and free the holding buffer. That word's first beat is presented on this cycle.
  - Cycle with clk_en_i=1, shift register empty and holding buffer empty: set underrun_o, drive dat_o all 1s, hold the counter.
  - Holding buffer freed and tx_valid_i on the same cycle: the new word is accepted.
- Outside TX: dat_oe_o=0 and dat_o is all 1s.
- L=1 with MaxLanes=8: only lane 0 carries data.

Test Plan:
- RX 1 lane, NumBits=32: shift 0xA5C30F96 MSb first over 32 enables, rx_ready_i=1 -> rx_data_o=0xA5C30F96 and rx_valid_o one cycle after beat 31. word_done_o pulses once.
- RX 4 lanes, clk_en_i toggling every other cycle: nibbles A,5,C,3,0,F,9,6 -> word after exactly 8 enabled cycles. Disabled cycles change nothing.
- RX overrun: two 8-lane words 0x11223344 then 0x55667788 with rx_ready_i=0 -> rx_data_o stays 0x11223344, overrun_o=1. A later start_i clears overrun_o.
- TX 8 lanes: tx words 0xDEADBEEF then 0x01234567 -> dat_o sequence DE,AD,BE,EF,01,23,45,67 with no gap, dat_oe_o=1. Then no word offered -> dat_o=FF, underrun_o=1.
- Abort: stop_i at RX beat 10 of 32 -> IDLE next cycle, busy_o=0, no rx_valid_o. New start -> a clean word is received.
- Async reset asserted mid-TX with no clock edge -> dat_oe_o=0 and dat_o=FF immediately; all flags 0 after release.
